// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: state encoding, frame width and default bit period.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_IDX_W        = $clog2(UART_DATA_BITS);
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: half_tick marks mid start bit,
// full_tick marks one full bit period since the last clear or wrap.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half_tick = (cnt == HALF_TC);
  assign full_tick = (cnt == FULL_TC);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low on rxd_s (blocked after a framing error until rxd_s seen high)
// ST_START  | timing to mid start bit to reject glitches
// ST_DATA   | sampling 8 data bits mid-bit, LSB first
// ST_PARITY | sampling the even-parity bit (parity build only)
// ST_STOP   | sampling the stop bit, then report the frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      rx_busy
);

  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state;
  uart_state_e               state_nx;
  logic                      sync_q1;
  logic                      rxd_s;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic                      need_high;

  logic timer_clear;
  logic half_tick;
  logic full_tick;
  logic shift_en;
  logic valid_nx;
  logic ferr_nx;

`ifdef UART_RX_PARITY_EN
  logic par_acc;
  logic par_bad;
  logic par_sample;
  logic perr_nx;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (timer_clear),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    timer_clear = 1'b0;
    shift_en    = 1'b0;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample  = 1'b0;
    perr_nx     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (!rxd_s && !need_high) begin
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (half_tick) begin
          if (rxd_s) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx    = ST_DATA;
            timer_clear = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_nx = ST_PARITY;
`else
            state_nx = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (full_tick) begin
          par_sample = 1'b1;
          state_nx   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (full_tick) begin
          state_nx = ST_IDLE;
          if (!rxd_s) begin
            ferr_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_nx = 1'b1;
`endif
          end else begin
            valid_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q1   <= 1'b1;
      rxd_s     <= 1'b1;
      shreg     <= '0;
      bit_idx   <= '0;
      need_high <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q1   <= rxd;
      rxd_s     <= sync_q1;
      rx_valid  <= valid_nx;
      frame_err <= ferr_nx;
      if (state == ST_IDLE) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        shreg   <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
        bit_idx <= bit_idx + UART_IDX_W'(1);
      end
      if (valid_nx) begin
        rx_data <= shreg;
      end
      // A held-low line after a bad stop bit is a break, not a new start.
      if (ferr_nx) begin
        need_high <= 1'b1;
      end else if (rxd_s) begin
        need_high <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_nx;
      if (state == ST_IDLE) begin
        par_acc <= 1'b0;
      end else if (shift_en) begin
        par_acc <= par_acc ^ rxd_s;
      end
      if (par_sample) begin
        par_bad <= par_acc ^ rxd_s;
      end
    end
  end
`endif

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = PAR_EN ? 10 : 9;
  localparam int LAT   = 2 + C / 2 + NBITS * C;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic       perr;

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log filled from the opposite clock edge.
  int         vq_t[$];
  logic [7:0] vq_d[$];
  int         fq_t[$];
  int         pq_t[$];
  int         overlap = 0;
  int         wide    = 0;
  int         n_valid = 0;
  logic       prev_v  = 1'b0;
  logic       prev_f  = 1'b0;
  logic       prev_p  = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq_t.push_back(cyc);
      vq_d.push_back(rx_data);
      n_valid <= n_valid + 1;
    end
    if (frame_err) fq_t.push_back(cyc);
    if (perr) pq_t.push_back(cyc);
    if ((rx_valid && frame_err) || (rx_valid && perr) || (frame_err && perr))
      overlap <= overlap + 1;
    if ((rx_valid && prev_v) || (frame_err && prev_f) || (perr && prev_p))
      wide <= wide + 1;
    prev_v <= rx_valid;
    prev_f <= frame_err;
    prev_p <= perr;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_good = 8'h00;
  int         exp_valid_total = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat);
    checks++;
    assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
      errors++;
      $error("FAIL %s: observed latency %0d expected %0d +/-1", tag, lat, LAT);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cycles(C);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            output int t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_flip);
    send_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic clear_log();
    vq_t.delete();
    vq_d.delete();
    fq_t.delete();
    pq_t.delete();
  endtask

  // Frame-level model: a low stop bit is a framing error; otherwise an odd count
  // of ones over data+parity is a parity error; otherwise the byte is delivered.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input int t0);
    logic [8:0] word;
    logic       exp_f;
    logic       exp_p;
    logic       exp_v;
    word  = {(^d) ^ par_flip, d};
    exp_f = !stop_bit;
    exp_p = stop_bit && PAR_EN && (^word);
    exp_v = stop_bit && !exp_p;
    chk({tag, "_nvalid"}, vq_t.size(), int'(exp_v));
    chk({tag, "_nferr"}, fq_t.size(), int'(exp_f));
    chk({tag, "_nperr"}, pq_t.size(), int'(exp_p));
    if (exp_v) begin
      last_good = d;
      exp_valid_total++;
      if (vq_t.size() > 0) begin
        chk({tag, "_data"}, int'(vq_d[0]), int'(d));
        chk_lat({tag, "_lat"}, vq_t[0] - t0);
      end
    end else begin
      chk({tag, "_hold"}, int'(rx_data), int'(last_good));
      if (exp_f && fq_t.size() > 0) chk_lat({tag, "_ferr_lat"}, fq_t[0] - t0);
      if (exp_p && pq_t.size() > 0) chk_lat({tag, "_perr_lat"}, pq_t[0] - t0);
    end
    clear_log();
  endtask

  initial begin
    int         t0;
    int         gap;
    logic [7:0] d;
    logic       busy_low;

    n_rst = 1'b0;
    rxd   = 1'b1;
    wait_cycles(5);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_rx_busy", int'(rx_busy), 0);
    chk("rst_parity_err", int'(perr), 0);
    n_rst = 1'b1;
    wait_cycles(C);

    send_frame(8'hAB, 1'b1, 1'b0, t0);
    check_frame("ab", 8'hAB, 1'b1, 1'b0, t0);
    wait_cycles(C);

    // Continuous transmitter of 0xAB: frames abut with no idle time.
    for (int i = 0; i < 3; i++) begin
      send_frame(8'b10101011, 1'b1, 1'b0, t0);
      check_frame($sformatf("loop%0d", i), 8'hAB, 1'b1, 1'b0, t0);
    end
    wait_cycles(C);

    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 2));
      send_frame(d, 1'b1, 1'b0, t0);
      check_frame($sformatf("rnd%0d", i), d, 1'b1, 1'b0, t0);
      wait_cycles(gap * C);
    end
    wait_cycles(C);

    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    busy_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rx_busy) begin
        busy_low = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("glitch_busy_low", int'(busy_low), 1);
    wait_cycles(2 * C);
    chk("glitch_nvalid", vq_t.size(), 0);
    chk("glitch_nferr", fq_t.size(), 0);
    clear_log();

    send_frame(8'h55, 1'b0, 1'b0, t0);
    check_frame("ferr55", 8'h55, 1'b0, 1'b0, t0);
    rxd = 1'b0;
    wait_cycles(3 * C);
    chk("break_busy", int'(rx_busy), 0);
    chk("break_nferr", fq_t.size(), 0);
    chk("break_nvalid", vq_t.size(), 0);
    clear_log();
    rxd = 1'b1;
    wait_cycles(C);
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    check_frame("after_break", 8'hA5, 1'b1, 1'b0, t0);
    wait_cycles(C);

    send_frame(8'h00, 1'b1, 1'b0, t0);
    check_frame("b2b_00", 8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t0);
    check_frame("b2b_ff", 8'hFF, 1'b1, 1'b0, t0);
    wait_cycles(C);

    d = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    wait_cycles(C / 2);
    n_rst = 1'b0;
    rxd   = 1'b1;
    wait_cycles(4);
    n_rst = 1'b1;
    wait_cycles(2 * C);
    chk("abort_nvalid", vq_t.size(), 0);
    chk("abort_nferr", fq_t.size(), 0);
    chk("abort_busy", int'(rx_busy), 0);
    chk("abort_rx_data", int'(rx_data), 0);
    clear_log();
    last_good = 8'h00;
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    check_frame("after_abort", 8'h3C, 1'b1, 1'b0, t0);
    wait_cycles(C);

    if (PAR_EN) begin
      send_frame(8'hAB, 1'b1, 1'b1, t0);
      check_frame("bad_parity", 8'hAB, 1'b1, 1'b1, t0);
      wait_cycles(C);
      send_frame(8'h3D, 1'b1, 1'b0, t0);
      check_frame("good_parity", 8'h3D, 1'b1, 1'b0, t0);
      wait_cycles(C);
    end

    wait_cycles(2 * C);
    chk("pulse_overlap", overlap, 0);
    chk("pulse_wide", wide, 0);
    chk("valid_total", n_valid, exp_valid_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
